// File: rtl/exec_monitor_pkg.sv
// Shared types and default constants for the execution monitor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package exec_monitor_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_REG_COUNT   = 32;
    localparam int DEF_ADDR_W      = 5;
    localparam int DEF_PC_W        = 32;
    localparam int DEF_HALT_ZEROS  = 1;
    localparam int DEF_TIMEOUT     = 65;
    localparam int DEF_TRACE_DEPTH = 16;

    // RUN is the only state that advances; the other two hold until reset
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    // One trace record at the default widths, head-first: pc, addr, data
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } trace_entry_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/exec_monitor_trace_fifo.sv
// Synchronous FIFO that drops pushes when full and keeps a sticky overflow flag.
// Latency: push visible at the head one edge later (no fall-through); pop on the same edge.
// Backpressure: none upstream (drop-on-full); downstream pops on o_vld & i_rdy.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;

    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign o_vld      = (r_count != '0);
    assign w_pop      = o_vld & i_rdy;
    // A pop on the same edge frees the slot, so a full FIFO still accepts
    assign w_push_ok  = i_push & (~w_full | w_pop);
    assign o_dat      = o_vld ? r_mem[r_rptr] : '0;
    assign o_overflow = r_overflow;

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            if (i_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    // Entry storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) r_mem[r_wptr] <= i_push_dat;
    end

endmodule

// File: rtl/exec_monitor.sv
// Execution monitor: shadow register file, end-of-program/timeout detection, optional trace (EXEC_MONITOR_TRACE_EN).
// Latency: status and shadow update one edge after the observed cycle; dbg_data is combinational, no bypass.
// Backpressure: none on the snooped datapath; trace pops on trace_valid & trace_ready, drops when full.
module exec_monitor
    import exec_monitor_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_COUNT   = DEF_REG_COUNT,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int PC_W        = DEF_PC_W,
    parameter int HALT_ZEROS  = DEF_HALT_ZEROS,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              halted,
    output logic              timed_out,
    output logic [31:0]       cycle_count,
    output logic [31:0]       retired_count,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [PC_W-1:0]   trace_pc,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_overflow
);
    state_t            r_state;
    logic              r_halted;
    logic              r_timed_out;
    logic [31:0]       r_cycle_cnt;
    logic [31:0]       r_retired_cnt;
    logic [31:0]       r_zero_run;
    logic [DATA_W-1:0] r_shadow [REG_COUNT];

    logic              w_run;
    logic              w_instr_nz;
    logic              w_wr_accept;
    logic [31:0]       w_cycle_nxt;
    logic [31:0]       w_retired_nxt;
    logic [31:0]       w_zero_nxt;

    assign w_run         = (r_state == ST_RUN);
    assign w_instr_nz    = |instruction;
    assign w_cycle_nxt   = sat_inc(r_cycle_cnt);
    assign w_retired_nxt = w_instr_nz ? sat_inc(r_retired_cnt) : r_retired_cnt;
    assign w_zero_nxt    = w_instr_nz ? 32'd0 : sat_inc(r_zero_run);
    // Register 0 is hardwired zero and out-of-range addresses have no backing entry
    assign w_wr_accept   = w_run && wr_en && (wr_addr != '0)
                           && (32'(wr_addr) < 32'(REG_COUNT));

    // Run-state FSM with counters; the zero-run check precedes timeout so halt wins a tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_halted      <= 1'b0;
            r_timed_out   <= 1'b0;
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
            r_zero_run    <= '0;
        end else if (r_state == ST_RUN) begin
            r_cycle_cnt   <= w_cycle_nxt;
            r_retired_cnt <= w_retired_nxt;
            r_zero_run    <= w_zero_nxt;
            if (w_zero_nxt == 32'(HALT_ZEROS)) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end else if (w_cycle_nxt == 32'(TIMEOUT)) begin
                r_state     <= ST_TIMEOUT;
                r_timed_out <= 1'b1;
            end
        end
    end

    // Shadow register file mirrors accepted writebacks, including the halting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) r_shadow[i] <= '0;
        end else if (w_wr_accept) begin
            r_shadow[wr_addr] <= wr_data;
        end
    end

    assign dbg_data = ((dbg_addr != '0) && (32'(dbg_addr) < 32'(REG_COUNT)))
                      ? r_shadow[dbg_addr] : '0;

    assign halted        = r_halted;
    assign timed_out     = r_timed_out;
    assign cycle_count   = r_cycle_cnt;
    assign retired_count = r_retired_cnt;

`ifdef EXEC_MONITOR_TRACE_EN
    localparam int ENTRY_W = PC_W + ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] w_trace_dat;

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_wr_accept),
        .i_push_dat ({pc, wr_addr, wr_data}),
        .o_vld      (trace_valid),
        .i_rdy      (trace_ready),
        .o_dat      (w_trace_dat),
        .o_overflow (trace_overflow)
    );

    assign {trace_pc, trace_addr, trace_data} = w_trace_dat;
`else
    // Without the trace the PC and pop handshake have no consumer
    logic w_unused_trace;
    assign w_unused_trace = ^{trace_ready, pc};

    assign trace_valid    = 1'b0;
    assign trace_pc       = '0;
    assign trace_addr     = '0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_exec_monitor.sv
module tb_exec_monitor;
    import exec_monitor_pkg::*;

    localparam int HZ    = 2;
    localparam int TO    = 8;
    localparam int DEPTH = 4;
`ifdef EXEC_MONITOR_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        halted;
    logic        timed_out;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic        trace_overflow;

    int n_vec = 0;
    int n_err = 0;

    exec_monitor #(
        .HALT_ZEROS  (HZ),
        .TIMEOUT     (TO),
        .TRACE_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instruction    (instruction),
        .pc             (pc),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .halted         (halted),
        .timed_out      (timed_out),
        .cycle_count    (cycle_count),
        .retired_count  (retired_count),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: program "ended" flags, plain counts, array and queue
    bit           m_halted, m_timed, m_ovf;
    int unsigned  m_cycles, m_retired, m_zrun;
    logic [31:0]  m_shadow [32];
    trace_entry_t m_trace [$];

    task automatic model_edge();
        bit ended, pop, acc;
        if (reset) begin
            m_halted = 0; m_timed = 0; m_ovf = 0;
            m_cycles = 0; m_retired = 0; m_zrun = 0;
            foreach (m_shadow[i]) m_shadow[i] = '0;
            m_trace.delete();
            return;
        end
        ended = m_halted || m_timed;
        pop   = TRACE_ON && (m_trace.size() != 0) && trace_ready;
        acc   = !ended && wr_en && (wr_addr != 0);
        if (!ended) begin
            m_cycles++;
            if (instruction != 0) begin m_retired++; m_zrun = 0; end
            else m_zrun++;
            if (m_zrun == HZ) m_halted = 1;
            else if (m_cycles == TO) m_timed = 1;
        end
        if (acc) m_shadow[wr_addr] = wr_data;
        if (pop) void'(m_trace.pop_front());
        if (acc && TRACE_ON) begin
            if (m_trace.size() < DEPTH) m_trace.push_back('{pc: pc, addr: wr_addr, data: wr_data});
            else m_ovf = 1;
        end
    endtask

    function automatic trace_entry_t model_head();
        return (m_trace.size() != 0) ? m_trace[0] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1; wr_en = 0; trace_ready = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; instruction = 32'h13; wr_en = 1; wr_addr = 5'd3; wr_data = 32'h5; trace_ready = 0;
        tick(); tick();
        dbg_addr = 5'd3; #1;
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %0h want 0", halted); end
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL reset_timed_out got %0h want 0", timed_out); end
        n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL reset_cycles got %0d want 0", cycle_count); end
        n_vec++; if (retired_count !== 32'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", retired_count); end
        n_vec++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL reset_dbg got %0h want 0", dbg_data); end
        n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_trace_valid got %0h want 0", trace_valid); end
        n_vec++; if (trace_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0h want 0", trace_overflow); end
        n_vec++; if ({trace_pc, trace_addr, trace_data} !== 69'd0) begin n_err++; $display("FAIL reset_trace_data got %0h want 0", {trace_pc, trace_addr, trace_data}); end
        reset = 0; wr_en = 0;
    endtask

    task automatic test_shadow_basic();
        apply_reset();
        instruction = 32'h00500293; pc = 32'h100; wr_en = 1; wr_addr = 5'd5; wr_data = 32'd7; dbg_addr = 5'd5;
        #1;
        n_vec++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL no_bypass got %0h want 0", dbg_data); end
        tick();
        pc = 32'h104; wr_addr = 5'd0; wr_data = 32'd9;
        tick();
        wr_en = 0; dbg_addr = 5'd5; #1;
        n_vec++; if (dbg_data !== 32'd7) begin n_err++; $display("FAIL shadow_r5 got %0h want 7", dbg_data); end
        dbg_addr = 5'd0; #1;
        n_vec++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL shadow_r0 got %0h want 0", dbg_data); end
        n_vec++; if (trace_valid !== TRACE_ON) begin n_err++; $display("FAIL basic_trace_valid got %0h want %0h", trace_valid, TRACE_ON); end
        n_vec++; if ({trace_pc, trace_addr, trace_data} !== (TRACE_ON ? {32'h100, 5'd5, 32'd7} : 69'd0)) begin
            n_err++; $display("FAIL basic_trace_entry got %0h/%0h/%0h", trace_pc, trace_addr, trace_data); end
        n_vec++; if (cycle_count !== 32'd2) begin n_err++; $display("FAIL basic_cycles got %0d want 2", cycle_count); end
    endtask

    task automatic test_halt();
        logic [31:0] seq [5];
        seq = '{32'h1111, 32'h0, 32'h2222, 32'h0, 32'h0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            instruction = seq[i];
            wr_en = (i == 4); wr_addr = 5'd7; wr_data = 32'h77;
            tick();
            if (i == 3) begin
                n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early got %0h want 0", halted); end
            end
        end
        wr_en = 0; dbg_addr = 5'd7; #1;
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag got %0h want 1", halted); end
        n_vec++; if (retired_count !== 32'd2) begin n_err++; $display("FAIL halt_retired got %0d want 2", retired_count); end
        n_vec++; if (cycle_count !== 32'd5) begin n_err++; $display("FAIL halt_cycles got %0d want 5", cycle_count); end
        n_vec++; if (dbg_data !== 32'h77) begin n_err++; $display("FAIL halt_edge_write got %0h want 77", dbg_data); end
        instruction = 32'h1; wr_en = 1; wr_addr = 5'd8; wr_data = 32'h88;
        tick(); tick();
        wr_en = 0; dbg_addr = 5'd8; #1;
        n_vec++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL halt_frozen_shadow got %0h want 0", dbg_data); end
        n_vec++; if (cycle_count !== 32'd5) begin n_err++; $display("FAIL halt_frozen_cycles got %0d want 5", cycle_count); end
    endtask

    task automatic test_timeout();
        apply_reset();
        instruction = 32'hABCD; wr_en = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL timeout_early got %0h want 0", timed_out); end
            end
        end
        n_vec++; if (timed_out !== 1'b1) begin n_err++; $display("FAIL timeout_flag got %0h want 1", timed_out); end
        n_vec++; if (cycle_count !== 32'd8) begin n_err++; $display("FAIL timeout_cycles got %0d want 8", cycle_count); end
        instruction = 32'h0; wr_en = 1; wr_addr = 5'd9; wr_data = 32'h99;
        tick(); tick(); tick();
        wr_en = 0; dbg_addr = 5'd9; #1;
        n_vec++; if (dbg_data !== 32'd0) begin n_err++; $display("FAIL timeout_write_ignored got %0h want 0", dbg_data); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL timeout_no_halt got %0h want 0", halted); end
    endtask

    task automatic test_halt_vs_timeout();
        apply_reset();
        wr_en = 0;
        for (int i = 1; i <= 8; i++) begin
            instruction = (i >= 7) ? 32'h0 : 32'h33;
            tick();
        end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL tie_halted got %0h want 1", halted); end
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL tie_timed_out got %0h want 0", timed_out); end
        n_vec++; if (retired_count !== 32'd6) begin n_err++; $display("FAIL tie_retired got %0d want 6", retired_count); end
    endtask

    task automatic test_trace_full();
        logic [31:0] exp_d [4];
        exp_d = '{32'h1002, 32'h1003, 32'h1004, 32'h1006};
        apply_reset();
        instruction = 32'h77;
        for (int i = 1; i <= 5; i++) begin
            pc = 32'h200 + 32'(4 * i); wr_en = 1; wr_addr = 5'(i); wr_data = 32'h1000 + 32'(i);
            tick();
        end
        n_vec++; if (trace_overflow !== TRACE_ON) begin n_err++; $display("FAIL full_overflow got %0h want %0h", trace_overflow, TRACE_ON); end
        n_vec++; if (trace_pc !== (TRACE_ON ? 32'h204 : 32'h0)) begin n_err++; $display("FAIL full_head_pc got %0h", trace_pc); end
        pc = 32'h260; wr_addr = 5'd6; wr_data = 32'h1006; trace_ready = 1;
        tick();
        wr_en = 0; trace_ready = 0;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (trace_valid !== TRACE_ON) begin n_err++; $display("FAIL drain_valid_%0d got %0h want %0h", k, trace_valid, TRACE_ON); end
            n_vec++; if (trace_data !== (TRACE_ON ? exp_d[k] : 32'h0)) begin n_err++; $display("FAIL drain_data_%0d got %0h want %0h", k, trace_data, TRACE_ON ? exp_d[k] : 32'h0); end
            trace_ready = 1; tick(); trace_ready = 0;
        end
        n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %0h want 0", trace_valid); end
        n_vec++; if (timed_out !== 1'b1) begin n_err++; $display("FAIL drain_timed_out got %0h want 1", timed_out); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            instruction = (i <= 4) ? 32'h55 : 32'h0;
            pc = 32'h300 + 32'(i); wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        wr_en = 0;
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL mid_halted got %0h want 1", halted); end
        n_vec++; if (trace_valid !== TRACE_ON) begin n_err++; $display("FAIL mid_trace_full got %0h want %0h", trace_valid, TRACE_ON); end
        reset = 1; trace_ready = 1; dbg_addr = 5'd1;
        tick();
        n_vec++; if ({halted, timed_out, trace_valid, trace_overflow} !== 4'b0) begin n_err++; $display("FAIL mid_reset_flags got %0b want 0000", {halted, timed_out, trace_valid, trace_overflow}); end
        n_vec++; if ({cycle_count, retired_count} !== 64'd0) begin n_err++; $display("FAIL mid_reset_counts got %0d/%0d want 0/0", cycle_count, retired_count); end
        n_vec++; if ({dbg_data, trace_data, trace_pc} !== 96'd0) begin n_err++; $display("FAIL mid_reset_data got %0h/%0h/%0h want 0", dbg_data, trace_data, trace_pc); end
        reset = 0; trace_ready = 0; instruction = 32'h99;
        tick();
        n_vec++; if (cycle_count !== 32'd1 || halted !== 1'b0) begin n_err++; $display("FAIL mid_resume got cycles %0d halted %0h want 1/0", cycle_count, halted); end
    endtask

    task automatic test_random();
        trace_entry_t h;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 19) == 0);
            instruction = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            pc          = $urandom;
            wr_en       = 1'($urandom_range(0, 1));
            wr_addr     = 5'($urandom_range(0, 31));
            wr_data     = $urandom;
            dbg_addr    = 5'($urandom_range(0, 31));
            trace_ready = 1'($urandom_range(0, 1));
            tick();
            h = model_head();
            n_vec++; if (halted !== m_halted) begin n_err++; $display("FAIL rnd_halted @%0d got %0h want %0h", n, halted, m_halted); end
            n_vec++; if (timed_out !== m_timed) begin n_err++; $display("FAIL rnd_timed_out @%0d got %0h want %0h", n, timed_out, m_timed); end
            n_vec++; if (cycle_count !== m_cycles) begin n_err++; $display("FAIL rnd_cycles @%0d got %0d want %0d", n, cycle_count, m_cycles); end
            n_vec++; if (retired_count !== m_retired) begin n_err++; $display("FAIL rnd_retired @%0d got %0d want %0d", n, retired_count, m_retired); end
            n_vec++; if (dbg_data !== (dbg_addr == 0 ? 32'h0 : m_shadow[dbg_addr])) begin n_err++; $display("FAIL rnd_dbg @%0d got %0h want %0h", n, dbg_data, m_shadow[dbg_addr]); end
            n_vec++; if (trace_valid !== (m_trace.size() != 0)) begin n_err++; $display("FAIL rnd_trace_valid @%0d got %0h want %0h", n, trace_valid, m_trace.size() != 0); end
            n_vec++; if ({trace_pc, trace_addr, trace_data} !== h) begin n_err++; $display("FAIL rnd_trace_head @%0d got %0h want %0h", n, {trace_pc, trace_addr, trace_data}, h); end
            n_vec++; if (trace_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow @%0d got %0h want %0h", n, trace_overflow, m_ovf); end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; instruction = 0; pc = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        dbg_addr = 0; trace_ready = 0;
        test_reset();
        test_shadow_basic();
        test_halt();
        test_timeout();
        test_halt_vs_timeout();
        test_trace_full();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
